blink_scheduler: RTL
====================

BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 SHALL have parameter WAIT_TIME, default 13500000, base clk cycles per LED step at speed 0.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 270000, consecutive stable cycles needed to accept a button level.
REQ-003 SHALL have parameter LONG_PRESS, default 27000000, debounced-low cycles that classify a press as long.
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port bbutton, input, 1, raw breadboard button, asynchronous, low = pressed.
REQ-007 SHALL have port led, output, 3, LED drive, active-low.
REQ-008 SHALL have port running, output, 1, high while state is RUN.

Function
REQ-009 SHALL pass bbutton through a 2-flop synchronizer, then debounce: debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-010 SHALL define press start as a debounced 1->0 transition and press end as a debounced 0->1 transition.
REQ-011 SHALL count press duration from press start, saturating at LONG_PRESS.
REQ-012 SHALL emit a one-cycle long event on the cycle the duration reaches LONG_PRESS while still held, and at most one long event per press.
REQ-013 SHALL emit a one-cycle short event at press end only if no long event fired for that press.
REQ-014 SHALL implement FSM states ARM, STOP, RUN, PAUSE.
REQ-015 SHALL define these transitions: ARM->STOP when the debounced level is high; STOP short->RUN; RUN short->RUN with speed+1; RUN long->PAUSE; PAUSE short->RUN; PAUSE long->STOP. Long events in STOP and all events in ARM SHALL be ignored.
REQ-016 SHALL use a 2-bit speed that wraps 3->0; step period = WAIT_TIME >> speed cycles.
REQ-017 SHALL, in RUN only, count a tick counter 0..period-1; on the period-1 cycle, reset the tick counter and increment the 3-bit step count, wrapping 7->0.
REQ-018 SHALL clear the tick counter on the same cycle as any speed change.
REQ-019 SHALL, in PAUSE, hold the tick counter and step count.
REQ-020 SHALL, on entry to STOP, clear the tick counter, step count and speed.
REQ-021 SHALL size the tick counter at $clog2(WAIT_TIME+1) bits, with no overflow at speed 0.
REQ-022 SHALL drive led = ~pattern as a registered output (one cycle after the step count changes).

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force: state ARM, synchronizer and debounced level 1, all counters 0, speed 0, led 3'b111, running 0.
REQ-024 SHALL, on reset mid-operation, discard any in-progress press and restart from ARM.
REQ-025 SHALL rely on rst_n deassertion being synchronized to clk upstream of this block.

Configuration
REQ-026 SHALL, with BLINK_GRAY_EN defined, set pattern = count ^ (count >> 1) (Gray code, one LED changes per step).
REQ-027 SHALL, with BLINK_GRAY_EN undefined, set pattern = count (plain binary).

Structure
REQ-028 SHALL place the FSM state enum typedef, the 2-bit speed typedef and the default parameter constants in package blink_pkg.
REQ-029 SHALL implement synchronizer and debounce as sub-module button_debounce, outputting the debounced level only; edge detection and classification stay in blink_scheduler.

Verification (WAIT_TIME=8, DEBOUNCE_CYCLES=4, LONG_PRESS=20)
REQ-030 Hold bbutton low through reset and for 50 cycles, then release -> state remains ARM and led stays 3'b111 until 4 stable-high cycles, then STOP; no short event generated.
REQ-031 In STOP, pulse bbutton low for 3 cycles -> no event and state STOP; then hold low 10 cycles -> short event on release, state RUN, running=1, led=3'b110 after 8 further cycles (binary build).
REQ-032 In RUN, three short presses -> speed 3, step count increments every cycle; a fourth short press -> speed 0, period 8, and the tick counter is 0 on the change cycle.
REQ-033 In RUN, hold low 30 cycles -> long event exactly 20 cycles after debounced press start, state PAUSE, led frozen, no short event on release; a second long press -> STOP, led 3'b111.
REQ-034 Run to count=2 -> led=3'b101 without BLINK_GRAY_EN, led=3'b100 with BLINK_GRAY_EN.
REQ-035 Assert rst_n low mid-RUN while the button is held -> immediate led=3'b111 and state ARM; after release, no stale event fires.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and default constants for the LED blink scheduler.
// BLINK_GRAY_EN selects a Gray-coded LED pattern; binary otherwise.
package blink_pkg;

  typedef enum logic [1:0] {StArm, StStop, StRun, StPause} state_e;

  typedef logic [1:0] speed_t;

  localparam int unsigned WaitTimeDefault       = 13500000;
  localparam int unsigned DebounceCyclesDefault = 270000;
  localparam int unsigned LongPressDefault      = 27000000;

  function automatic logic [2:0] step_pattern(input logic [2:0] count);
`ifdef BLINK_GRAY_EN
    return count ^ (count >> 1);
`else
    return count;
`endif
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability debounce for an active-low button.
// Output is the accepted (debounced) level only.
module button_debounce
  import blink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic level_o
);

  localparam int unsigned   CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle agreeing with the accepted level restarts the window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/blink_scheduler.sv
// Button-driven LED step scheduler: short/long press classification and a RUN/PAUSE/STOP FSM.
// Define BLINK_GRAY_EN for a Gray-coded LED pattern (see blink_pkg::step_pattern).
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int unsigned WAIT_TIME       = WaitTimeDefault,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned LONG_PRESS      = LongPressDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bbutton,
  output logic [2:0] led,
  output logic       running
);

  localparam int unsigned TickW = $clog2(WAIT_TIME + 1);
  localparam int unsigned DurW  = $clog2(LONG_PRESS + 1);
  // Covers synchronizer latency plus a full debounce window, so a button
  // held through reset is seen low before ARM can leave.
  localparam int unsigned    ArmSettle = DEBOUNCE_CYCLES + 3;
  localparam int unsigned    ArmW      = $clog2(ArmSettle + 1);
  localparam logic [DurW-1:0] DurMax   = DurW'(LONG_PRESS);
  localparam logic [ArmW-1:0] ArmMax   = ArmW'(ArmSettle - 1);

  logic             db_level, db_prev_q;
  logic             press_start, press_end, long_evt, short_evt;
  logic             press_active_q, press_active_d, long_fired_q, long_fired_d;
  logic [DurW-1:0]  dur_q, dur_d;
  logic [ArmW-1:0]  arm_cnt_q, arm_cnt_d;
  state_e           state_q, state_d;
  speed_t           speed_q, speed_d;
  logic [TickW-1:0] tick_q, tick_d, period_m1;
  logic [2:0]       count_q, count_d, led_q, led_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .button_i(bbutton),
    .level_o (db_level)
  );

  assign press_start = db_prev_q & ~db_level;
  assign press_end   = ~db_prev_q & db_level;
  // Presses that begin in ARM never produce events.
  assign long_evt  = press_active_q & ~db_level & (dur_q == DurMax) & ~long_fired_q;
  assign short_evt = press_end & press_active_q & ~long_fired_q;
  assign period_m1 = TickW'(WAIT_TIME >> speed_q) - 1'b1;

  always_comb begin
    dur_d          = dur_q;
    press_active_d = press_active_q;
    long_fired_d   = long_fired_q;
    arm_cnt_d      = '0;
    if (db_level) begin
      dur_d = '0;
    end else if (dur_q != DurMax) begin
      dur_d = dur_q + 1'b1;
    end
    if (press_start) begin
      press_active_d = (state_q != StArm);
    end else if (press_end) begin
      press_active_d = 1'b0;
    end
    if (press_end) begin
      long_fired_d = 1'b0;
    end else if (long_evt) begin
      long_fired_d = 1'b1;
    end
    if (state_q == StArm && db_level) begin
      arm_cnt_d = (arm_cnt_q == ArmMax) ? arm_cnt_q : arm_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArm:   if (db_level && arm_cnt_q == ArmMax) state_d = StStop;
      StStop:  if (short_evt) state_d = StRun;
      StRun:   if (long_evt) state_d = StPause;
      StPause: begin
        if (short_evt)     state_d = StRun;
        else if (long_evt) state_d = StStop;
      end
      default: state_d = StArm;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    tick_d  = tick_q;
    count_d = count_q;
    if (state_d == StStop && state_q != StStop) begin
      speed_d = '0;
      tick_d  = '0;
      count_d = '0;
    end else if (state_q == StRun) begin
      if (short_evt) begin
        speed_d = speed_q + 1'b1;
        tick_d  = '0;
      end else if (tick_q == period_m1) begin
        tick_d  = '0;
        count_d = count_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
    led_d = ~step_pattern(count_q);
  end

  always_comb begin
    running = (state_q == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q      <= 1'b1;
      dur_q          <= '0;
      press_active_q <= 1'b0;
      long_fired_q   <= 1'b0;
      arm_cnt_q      <= '0;
      state_q        <= StArm;
      speed_q        <= '0;
      tick_q         <= '0;
      count_q        <= '0;
      led_q          <= 3'b111;
    end else begin
      db_prev_q      <= db_level;
      dur_q          <= dur_d;
      press_active_q <= press_active_d;
      long_fired_q   <= long_fired_d;
      arm_cnt_q      <= arm_cnt_d;
      state_q        <= state_d;
      speed_q        <= speed_d;
      tick_q         <= tick_d;
      count_q        <= count_d;
      led_q          <= led_d;
    end
  end

  assign led = led_q;

endmodule
